// File: rtl/vmem_console_ctrl.sv
// Text-console write controller: turns ASCII keys into character-memory writes and owns the cursor.
// Optional TAB handling is enabled by defining VMEM_CONSOLE_TAB_EN.
module vmem_console_ctrl #(
  parameter int COLS = 70,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  key_in,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic        clr_req,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WRITE   = 2'd1;
  localparam logic [1:0] S_CLR_ROW = 2'd2;
  localparam logic [1:0] S_CLR_ALL = 2'd3;

  localparam logic [6:0] LAST_X = 7'(COLS - 1);
  localparam logic [4:0] LAST_Y = 5'(ROWS - 1);

  logic [1:0]  r_state;
  logic [6:0]  r_cx;
  logic [4:0]  r_cy;
  logic        r_clrPend;
  logic        r_rowClr;
  logic [6:0]  r_sx;
  logic [4:0]  r_sy;
  logic        r_we;
  logic [11:0] r_addr;
  logic [7:0]  r_wdata;
  logic        r_busy;

  logic        w_startClr;
  logic        w_accept;
  logic        w_isPrint;
  logic        w_isEnter;
  logic        w_isBs;
  logic        w_bsMove;
  logic [6:0]  w_bsX;
  logic [4:0]  w_bsY;
  logic [4:0]  w_nextRow;
  logic [6:0]  w_sxInc;
  logic [4:0]  w_syInc;
  logic        w_tabMove;
  logic        w_tabWrap;
  logic [6:0]  w_tabDstX;

  assign key_ready  = (r_state == S_IDLE) && !clr_req && !r_clrPend;
  assign w_startClr = (r_state == S_IDLE) && (clr_req || r_clrPend);
  assign w_accept   = key_valid && key_ready;

  assign w_isPrint = (key_in >= 8'h20) && (key_in <= 8'h7E);
  assign w_isEnter = (key_in == 8'h0A);
  assign w_isBs    = (key_in == 8'h08);

  // Backspace at column 0 steps back to the last column of the previous row.
  assign w_bsMove  = (r_cx != 7'd0) || (r_cy != 5'd0);
  assign w_bsX     = (r_cx != 7'd0) ? r_cx - 7'd1 : LAST_X;
  assign w_bsY     = (r_cx != 7'd0) ? r_cy : r_cy - 5'd1;
  assign w_nextRow = (r_cy == LAST_Y) ? 5'd0 : r_cy + 5'd1;
  assign w_sxInc   = r_sx + 7'd1;
  assign w_syInc   = r_sy + 5'd1;

`ifdef VMEM_CONSOLE_TAB_EN
  localparam logic [7:0] COLS8 = 8'(COLS);
  logic       w_isTab;
  logic [7:0] w_tabX;
  // Computed in 8 bits so a tab stop at 128 does not alias back to column 0.
  assign w_isTab   = (key_in == 8'h09);
  assign w_tabX    = {1'b0, r_cx[6:3], 3'b000} + 8'd8;
  assign w_tabWrap = w_isTab && (w_tabX >= COLS8);
  assign w_tabMove = w_isTab && (w_tabX < COLS8);
  assign w_tabDstX = w_tabX[6:0];
`else
  assign w_tabWrap = 1'b0;
  assign w_tabMove = 1'b0;
  assign w_tabDstX = 7'd0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cx      <= 7'd0;
      r_cy      <= 5'd0;
      r_clrPend <= 1'b0;
      r_rowClr  <= 1'b0;
      r_sx      <= 7'd0;
      r_sy      <= 5'd0;
      r_we      <= 1'b0;
      r_addr    <= 12'd0;
      r_wdata   <= 8'd0;
      r_busy    <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (clr_req && ((r_state == S_WRITE) || (r_state == S_CLR_ROW))) begin
        r_clrPend <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_startClr) begin
            r_state   <= S_CLR_ALL;
            r_clrPend <= 1'b0;
            r_cx      <= 7'd0;
            r_cy      <= 5'd0;
            r_sx      <= 7'd0;
            r_sy      <= 5'd0;
            r_we      <= 1'b1;
            r_addr    <= 12'd0;
            r_wdata   <= 8'd0;
            r_busy    <= 1'b1;
          end else if (w_accept) begin
            if (w_isPrint) begin
              r_state <= S_WRITE;
              r_we    <= 1'b1;
              r_addr  <= {r_cx, r_cy};
              r_wdata <= key_in;
              r_busy  <= 1'b1;
              if (r_cx == LAST_X) begin
                r_cx     <= 7'd0;
                r_cy     <= w_nextRow;
                r_rowClr <= 1'b1;
              end else begin
                r_cx     <= r_cx + 7'd1;
                r_rowClr <= 1'b0;
              end
            end else if (w_isEnter || w_tabWrap) begin
              r_state <= S_CLR_ROW;
              r_cx    <= 7'd0;
              r_cy    <= w_nextRow;
              r_sx    <= 7'd0;
              r_we    <= 1'b1;
              r_addr  <= {7'd0, w_nextRow};
              r_wdata <= 8'd0;
              r_busy  <= 1'b1;
            end else if (w_tabMove) begin
              r_cx <= w_tabDstX;
            end else if (w_isBs && w_bsMove) begin
              r_state  <= S_WRITE;
              r_cx     <= w_bsX;
              r_cy     <= w_bsY;
              r_rowClr <= 1'b0;
              r_we     <= 1'b1;
              r_addr   <= {w_bsX, w_bsY};
              r_wdata  <= 8'd0;
              r_busy   <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (r_rowClr) begin
            r_state  <= S_CLR_ROW;
            r_rowClr <= 1'b0;
            r_sx     <= 7'd0;
            r_we     <= 1'b1;
            r_addr   <= {7'd0, r_cy};
            r_wdata  <= 8'd0;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_CLR_ROW: begin
          if (r_sx == LAST_X) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_sx   <= w_sxInc;
            r_we   <= 1'b1;
            r_addr <= {w_sxInc, r_cy};
          end
        end
        default: begin
          // Raster sweep: x is the inner counter, y the outer one.
          if (r_sx == LAST_X) begin
            if (r_sy == LAST_Y) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_sx   <= 7'd0;
              r_sy   <= w_syInc;
              r_we   <= 1'b1;
              r_addr <= {7'd0, w_syInc};
            end
          end else begin
            r_sx   <= w_sxInc;
            r_we   <= 1'b1;
            r_addr <= {w_sxInc, r_sy};
          end
        end
      endcase
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign cursor_x  = r_cx;
  assign cursor_y  = r_cy;
  assign busy      = r_busy;

endmodule

// File: tb/tb_vmem_console_ctrl.sv
// Testbench for vmem_console_ctrl: directed and random keys checked against a screen/cursor model.
module tb_vmem_console_ctrl;

  localparam int COLS  = 70;
  localparam int ROWS  = 30;
  localparam int BOUND = 5000;

  logic        clk;
  logic        reset;
  logic [7:0]  key_in;
  logic        key_valid;
  logic        key_ready;
  logic        clr_req;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        busy;

  vmem_console_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .clr_req   (clr_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .busy      (busy)
  );

  int testCount = 0;
  int failCount = 0;

  // Model state: expected screen contents and cursor.
  logic [7:0] mdl[0:127][0:31];
  int mx;
  int my;

  // Observed screen, rebuilt from the write strobes.
  logic [7:0] shadow[0:127][0:31];
  int writeCount = 0;
  int badAddr = 0;
  bit orderCheck = 0;
  int ordIdx = 0;
  int ordErr = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe writes mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      writeCount++;
      if ((int'(mem_addr[11:5]) >= COLS) || (int'(mem_addr[4:0]) >= ROWS)) badAddr++;
      else shadow[mem_addr[11:5]][mem_addr[4:0]] = mem_wdata;
      if (orderCheck) begin
        if ((int'(mem_addr[11:5]) != (ordIdx % COLS)) || (int'(mem_addr[4:0]) != (ordIdx / COLS)) ||
            (mem_wdata !== 8'h00)) ordErr++;
        ordIdx++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelNewline(inout int w);
    mx = 0;
    my = (my + 1) % ROWS;
    for (int x = 0; x < COLS; x++) mdl[x][my] = 8'h00;
    w += COLS;
  endtask

  task automatic modelClear();
    for (int x = 0; x < COLS; x++)
      for (int y = 0; y < ROWS; y++) mdl[x][y] = 8'h00;
    mx = 0;
    my = 0;
  endtask

  // Applies one key to the model and returns how many memory writes it should cause.
  task automatic modelKey(input logic [7:0] k, output int w);
    int t;
    w = 0;
    if (k >= 8'h20 && k <= 8'h7E) begin
      mdl[mx][my] = k;
      w = 1;
      if (mx == COLS - 1) modelNewline(w);
      else mx++;
    end else if (k == 8'h0A) begin
      modelNewline(w);
    end else if (k == 8'h08) begin
      if (mx > 0) begin
        mx--;
        mdl[mx][my] = 8'h00;
        w = 1;
      end else if (my > 0) begin
        mx = COLS - 1;
        my--;
        mdl[mx][my] = 8'h00;
        w = 1;
      end
`ifdef VMEM_CONSOLE_TAB_EN
    end else if (k == 8'h09) begin
      t = (mx / 8 + 1) * 8;
      if (t >= COLS) modelNewline(w);
      else mx = t;
`endif
    end
  endtask

  function automatic int screenDiffs();
    int d = 0;
    for (int x = 0; x < COLS; x++)
      for (int y = 0; y < ROWS; y++)
        if (shadow[x][y] !== mdl[x][y]) d++;
    return d;
  endfunction

  // Sends one key, optionally pulses clr_req while the key is being processed, then checks everything.
  task automatic applyStimulus(input logic [7:0] k, input bit clrDuring);
    int expW;
    int w0;
    int cyc;
    modelKey(k, expW);
    if (clrDuring) begin
      modelClear();
      expW += COLS * ROWS;
    end
    w0 = writeCount;
    @(negedge clk);
    key_in = k;
    key_valid = 1'b1;
    cyc = 0;
    while (key_ready !== 1'b1 && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("acceptWait", 32'(cyc < BOUND), 32'd1);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("busyN1 key=%02h", k), 32'(busy), 32'((expW > 0) ? 1 : 0));
    checkOutput($sformatf("readyN1 key=%02h", k), 32'(key_ready), 32'((expW > 0) ? 0 : 1));
    if (clrDuring) begin
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
    end
    cyc = 0;
    while ((busy !== 1'b0 || key_ready !== 1'b1) && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
    end
    #1;
    checkOutput("idleWait", 32'(cyc < BOUND), 32'd1);
    checkOutput($sformatf("writes key=%02h", k), 32'(writeCount - w0), 32'(expW));
    checkOutput($sformatf("cursorX key=%02h", k), 32'(cursor_x), 32'(mx));
    checkOutput($sformatf("cursorY key=%02h", k), 32'(cursor_y), 32'(my));
    checkOutput($sformatf("screen key=%02h", k), 32'(screenDiffs()), 32'd0);
  endtask

  initial begin
    int cyc;
    int w0;
    int r;
    logic [7:0] k;

    for (int x = 0; x < 128; x++)
      for (int y = 0; y < 32; y++) begin
        mdl[x][y] = 8'h00;
        shadow[x][y] = 8'h00;
      end
    mx = 0;
    my = 0;
    reset = 1'b0;
    key_in = 8'h00;
    key_valid = 1'b0;
    clr_req = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset state.
    checkOutput("rstReady", 32'(key_ready), 32'd1);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstWe", 32'(mem_we), 32'd0);
    checkOutput("rstAddr", 32'(mem_addr), 32'd0);
    checkOutput("rstData", 32'(mem_wdata), 32'd0);
    checkOutput("rstCx", 32'(cursor_x), 32'd0);
    checkOutput("rstCy", 32'(cursor_y), 32'd0);

    // First key 'A' with cycle-exact timing.
    modelKey(8'h41, r);
    key_in = 8'h41;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    @(negedge clk);
    checkOutput("aWe", 32'(mem_we), 32'd1);
    checkOutput("aAddr", 32'(mem_addr), 32'd0);
    checkOutput("aData", 32'(mem_wdata), 32'h41);
    checkOutput("aCx", 32'(cursor_x), 32'd1);
    checkOutput("aReadyN1", 32'(key_ready), 32'd0);
    @(negedge clk);
    checkOutput("aReadyN2", 32'(key_ready), 32'd1);
    checkOutput("aWeN2", 32'(mem_we), 32'd0);

    // 70 more printable keys: line wraps into row 1, which gets cleared.
    for (int i = 0; i < 70; i++) applyStimulus(8'($urandom_range(32, 126)), 1'b0);

    // Backspace at (0,3) steps back to (69,2).
    applyStimulus(8'h0A, 1'b0);
    applyStimulus(8'h0A, 1'b0);
    checkOutput("preBsCy", 32'(cursor_y), 32'd3);
    applyStimulus(8'h08, 1'b0);

    // Clear requested in the same cycle as a valid key: clear wins, key follows.
    @(negedge clk);
    w0 = writeCount;
    key_in = 8'h5A;
    key_valid = 1'b1;
    clr_req = 1'b1;
    ordIdx = 0;
    ordErr = 0;
    orderCheck = 1'b1;
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    @(negedge clk);
    checkOutput("clrReady", 32'(key_ready), 32'd0);
    checkOutput("clrWe", 32'(mem_we), 32'd1);
    checkOutput("clrCx", 32'(cursor_x), 32'd0);
    checkOutput("clrCy", 32'(cursor_y), 32'd0);
    cyc = 0;
    while (key_ready !== 1'b1 && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
    end
    orderCheck = 1'b0;
    checkOutput("clrWait", 32'(cyc < BOUND), 32'd1);
    checkOutput("clrWrites", 32'(writeCount - w0), 32'(COLS * ROWS));
    checkOutput("clrOrder", 32'(ordErr), 32'd0);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    modelClear();
    modelKey(8'h5A, r);
    cyc = 0;
    while (busy !== 1'b0 && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
    end
    #1;
    checkOutput("postClrKeyCx", 32'(cursor_x), 32'(mx));
    checkOutput("postClrScreen", 32'(screenDiffs()), 32'd0);

    // Backspace to (0,0), then backspace at (0,0) is a no-op.
    applyStimulus(8'h08, 1'b0);
    applyStimulus(8'h08, 1'b0);

    // ENTER from (5,29) wraps to row 0 and clears it.
    for (int i = 0; i < 29; i++) applyStimulus(8'h0A, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(8'($urandom_range(32, 126)), 1'b0);
    checkOutput("preWrapCy", 32'(cursor_y), 32'd29);
    applyStimulus(8'h0A, 1'b0);

    // Clear request arriving during a row clear is held until the row clear ends.
    applyStimulus(8'h0A, 1'b1);

    // TAB at (3,0) and near the end of a row.
    for (int i = 0; i < 3; i++) applyStimulus(8'($urandom_range(32, 126)), 1'b0);
    applyStimulus(8'h09, 1'b0);
    while (mx < 65) applyStimulus(8'($urandom_range(32, 126)), 1'b0);
    applyStimulus(8'h09, 1'b0);

    // Random key stream.
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) k = 8'($urandom_range(32, 126));
      else if (r == 6) k = 8'h0A;
      else if (r == 7) k = 8'h08;
      else if (r == 8) k = 8'h09;
      else k = 8'($urandom_range(0, 255));
      applyStimulus(k, 1'b0);
    end

    checkOutput("badAddr", 32'(badAddr), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
